tlb_controller: RTL and testbench

Sequences the shared TLB on behalf of two translation requesters: fetch on port 0, load/store on port 1. It arbitrates round-robin, pulses the TLB lookup and samples hit/fault. On a fault it walks a single-level page table over a memory read handshake, then refills the TLB with `unfault` and replays the lookup. It sits between the pipeline front-ends and the TLB/cache complex and is the only driver of the TLB's `enable`, `unfault`, `compare_input` and `fault_input`.

---
 rtl/cpu_params.sv | 17 +
 rtl/tlb_rr_arbiter.sv | 25 ++
 rtl/tlb_controller.sv | 148 ++++++++++++++
 tb/tb_tlb_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_params.sv
// Shared CPU-wide constants and the TLB controller state encoding.
package cpu_params;
    localparam int bit_count     = 32;
    localparam int page_size     = 4096;
    localparam int pte_valid_bit = 0;
    localparam int pte_bytes     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        WALK,
        REFILL,
        FLUSH,
        RESPOND
    } tlb_ctrl_state_t;
endpackage

// File: rtl/tlb_rr_arbiter.sv
// Two-port round-robin arbiter; the pointer flips to the other port after every grant.
module tlb_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       advance,
    output logic       grant_idx,
    output logic       grant_any
);
    logic rr;

    always_comb begin
        grant_any = |req_valid;
        // A lone requester wins outright; the pointer only matters on contention.
        grant_idx = (req_valid == 2'b11) ? rr : req_valid[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= 1'b0;
        end else if (advance && grant_any) begin
            rr <= ~grant_idx;
        end
    end
endmodule

// File: rtl/tlb_controller.sv
// Sequences the shared TLB for fetch (port 0) and load/store (port 1): lookup,
// single-level page-table walk on a miss, refill and replay.
module tlb_controller
    import cpu_params::*;
#(
    parameter logic [bit_count-1:0] pt_base = 32'h0001_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    input  logic [1:0][bit_count-1:0] req_vaddr,
    output logic [1:0]                req_done,
    output logic [bit_count-1:0]      req_paddr,
    output logic                      req_pfault,
    output logic                      tlb_enable,
    output logic                      tlb_unfault,
    output logic                      tlb_flush,
    output logic [bit_count-1:0]      tlb_compare,
    output logic [bit_count-1:0]      tlb_fault_input,
    input  logic [bit_count-1:0]      tlb_paddr,
    input  logic                      tlb_fault,
    output logic                      mem_req,
    output logic [bit_count-1:0]      mem_addr,
    input  logic                      mem_ack,
    input  logic [bit_count-1:0]      mem_rdata
);
    localparam int off_w  = $clog2(page_size);
    localparam int pte_sh = $clog2(pte_bytes);

    tlb_ctrl_state_t      state;
    logic                 gnt;
    logic [bit_count-1:0] vaddr;
    logic                 replayed;
    logic                 flush_2nd;
    logic                 grant_idx;
    logic                 grant_any;
    logic                 advance;
    logic [bit_count-1:0] pte_addr;
    logic                 unused_bits;

    assign advance     = (state == IDLE);
    // Wraps modulo 2^bit_count by construction.
    assign pte_addr    = pt_base + ((vaddr >> off_w) << pte_sh);
    assign unused_bits = ^{tlb_paddr[off_w-1:0], mem_rdata[off_w-1:0]};

    tlb_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .advance   (advance),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            gnt             <= 1'b0;
            vaddr           <= '0;
            replayed        <= 1'b0;
            flush_2nd       <= 1'b0;
            req_done        <= '0;
            req_paddr       <= '0;
            req_pfault      <= 1'b0;
            tlb_enable      <= 1'b0;
            tlb_unfault     <= 1'b0;
            tlb_flush       <= 1'b0;
            tlb_compare     <= '0;
            tlb_fault_input <= '0;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
        end else begin
            tlb_enable  <= 1'b0;
            tlb_unfault <= 1'b0;
            tlb_flush   <= 1'b0;
            req_done    <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gnt         <= grant_idx;
                        vaddr       <= req_vaddr[grant_idx];
                        tlb_compare <= req_vaddr[grant_idx];
                        replayed    <= 1'b0;
                        tlb_enable  <= 1'b1;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: state <= CHECK;
                CHECK: begin
                    if (!tlb_fault) begin
                        req_paddr     <= {tlb_paddr[bit_count-1:off_w], vaddr[off_w-1:0]};
                        req_pfault    <= 1'b0;
                        req_done[gnt] <= 1'b1;
                        state         <= RESPOND;
                    end else if (replayed) begin
                        // Entry we just refilled still misses: report as a page fault.
                        req_paddr     <= '0;
                        req_pfault    <= 1'b1;
                        req_done[gnt] <= 1'b1;
                        state         <= RESPOND;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= pte_addr;
                        state    <= WALK;
                    end
                end
                WALK: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        mem_addr    <= '0;
                        tlb_unfault <= 1'b1;
                        if (mem_rdata[pte_valid_bit]) begin
                            tlb_fault_input <= {mem_rdata[bit_count-1:off_w], {off_w{1'b0}}};
                            state           <= REFILL;
                        end else begin
                            tlb_fault_input <= '0;
                            flush_2nd       <= 1'b0;
                            state           <= FLUSH;
                        end
                    end
                end
                REFILL: begin
                    replayed   <= 1'b1;
                    tlb_enable <= 1'b1;
                    state      <= LOOKUP;
                end
                FLUSH: begin
                    // First cycle carries the unfault release, second the flush.
                    if (!flush_2nd) begin
                        tlb_flush <= 1'b1;
                        flush_2nd <= 1'b1;
                    end else begin
                        req_paddr     <= '0;
                        req_pfault    <= 1'b1;
                        req_done[gnt] <= 1'b1;
                        state         <= RESPOND;
                    end
                end
                RESPOND: begin
                    req_paddr  <= '0;
                    req_pfault <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_controller.sv
// Directed bench for tlb_controller with a small TLB model and a page-table memory responder.
module tb_tlb_controller;
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0][31:0]  req_vaddr = '0;
    logic [1:0]        req_done;
    logic [31:0]       req_paddr;
    logic              req_pfault;
    logic              tlb_enable, tlb_unfault, tlb_flush;
    logic [31:0]       tlb_compare, tlb_fault_input;
    logic [31:0]       tlb_paddr = '0;
    logic              tlb_fault = 1'b0;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tlb_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_vaddr(req_vaddr),
        .req_done(req_done), .req_paddr(req_paddr), .req_pfault(req_pfault),
        .tlb_enable(tlb_enable), .tlb_unfault(tlb_unfault), .tlb_flush(tlb_flush),
        .tlb_compare(tlb_compare), .tlb_fault_input(tlb_fault_input),
        .tlb_paddr(tlb_paddr), .tlb_fault(tlb_fault),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // 4-entry TLB model: lookup result appears the cycle after tlb_enable.
    logic [19:0] m_vpn [4];
    logic [19:0] m_ppn [4];
    logic [3:0]  m_v = '0;
    logic [1:0]  m_ptr = '0;
    logic        force_fault = 1'b0;
    logic        pre_wr = 1'b0;
    logic [19:0] pre_vpn = '0, pre_ppn = '0;

    always @(posedge clk or negedge rst) begin : tlb_model
        logic        hit;
        logic [19:0] pp;
        if (!rst) begin
            m_v       <= '0;
            m_ptr     <= '0;
            tlb_fault <= 1'b0;
            tlb_paddr <= '0;
        end else begin
            if (tlb_flush) begin
                m_v <= '0;
            end else if (tlb_unfault || pre_wr) begin
                m_vpn[m_ptr] <= tlb_unfault ? tlb_compare[31:12] : pre_vpn;
                m_ppn[m_ptr] <= tlb_unfault ? tlb_fault_input[31:12] : pre_ppn;
                m_v[m_ptr]   <= 1'b1;
                m_ptr        <= m_ptr + 2'd1;
            end
            if (tlb_enable) begin
                hit = 1'b0;
                pp  = '0;
                for (int i = 0; i < 4; i++)
                    if (m_v[i] && m_vpn[i] == tlb_compare[31:12]) begin
                        hit = 1'b1;
                        pp  = m_ppn[i];
                    end
                tlb_fault <= force_fault || !hit;
                tlb_paddr <= hit ? {pp, 12'h000} : 32'h0;
            end
        end
    end

    // Page-table memory: acks mem_lat cycles after mem_req rises.
    int          mem_lat = 0;
    logic [31:0] mem_data = '0;
    initial begin : mem_resp
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (seen == mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data;
                end else begin
                    mem_ack = 1'b0;
                end
                seen++;
            end else begin
                seen    = 0;
                mem_ack = 1'b0;
            end
        end
    end

    // Protocol monitor
    int          n_walk = 0, n_overlap = 0, n_wide = 0, u_cyc = 0, f_cyc = 0;
    logic [31:0] walk_addr = '0, fi_cap = '0;
    logic        p_en = 0, p_uf = 0, p_fl = 0, p_mr = 0;
    logic [1:0]  p_dn = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (int'(tlb_enable) + int'(tlb_unfault) + int'(tlb_flush)
                + int'(req_done[0]) + int'(req_done[1]) > 1)
                n_overlap <= n_overlap + 1;
            if ((tlb_enable && p_en) || (tlb_unfault && p_uf) || (tlb_flush && p_fl)
                || (|(req_done & p_dn)))
                n_wide <= n_wide + 1;
            if (mem_req && !p_mr) begin
                n_walk    <= n_walk + 1;
                walk_addr <= mem_addr;
            end
            if (tlb_unfault) begin
                u_cyc  <= cyc;
                fi_cap <= tlb_fault_input;
            end
            if (tlb_flush) f_cyc <= cyc;
        end
        p_en <= tlb_enable;
        p_uf <= tlb_unfault;
        p_fl <= tlb_flush;
        p_dn <= req_done;
        p_mr <= mem_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [19:0] v, input logic [19:0] p);
        @(negedge clk);
        pre_vpn = v;
        pre_ppn = p;
        pre_wr  = 1'b1;
        @(negedge clk);
        pre_wr  = 1'b0;
    endtask

    task automatic run_txn(input int p, input logic [31:0] va, output int lat,
                           output logic [31:0] pa, output logic pf, output int dcyc);
        logic got;
        @(negedge clk);
        req_valid[p] = 1'b1;
        req_vaddr[p] = va;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = req_done[p];
        end
        chk("done_seen", {31'b0, got}, 32'd1);
        pa   = req_paddr;
        pf   = req_pfault;
        dcyc = cyc;
        req_valid[p] = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic [31:0] vaddr;
        logic [31:0] paddr;
        logic        pfault;
        int          lat;
    } vec_t;

    vec_t        vecs [4];
    int          lat, dcyc, w0;
    logic [31:0] pa;
    logic        pf;
    logic        outs_or;
    int          dc [4];
    logic [31:0] apa [4];
    logic        aport [4];

    assign outs_or = |{req_done, req_paddr, req_pfault, tlb_enable, tlb_unfault, tlb_flush,
                       tlb_compare, tlb_fault_input, mem_req, mem_addr};

    initial begin
        vecs[0] = '{1, 32'hFFFFF00B, 32'h1000000B, 1'b0, 3};
        vecs[1] = '{0, 32'h00003FFF, 32'hABCDEFFF, 1'b0, 3};
        vecs[2] = '{1, 32'h12345000, 32'h00077000, 1'b0, 3};
        vecs[3] = '{0, 32'hFFFFFFFF, 32'h10000FFF, 1'b0, 3};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {31'b0, outs_or}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Miss, walk with 2-cycle ack, refill, replay hit
        mem_lat = 2; mem_data = 32'h10000001; w0 = n_walk;
        run_txn(0, 32'hFFFFF00A, lat, pa, pf, dcyc);
        chk("miss_walk_addr", walk_addr, 32'h0040FFFC);
        chk("miss_fault_input", fi_cap, 32'h10000000);
        chk("miss_paddr", pa, 32'h1000000A);
        chk("miss_pfault", {31'b0, pf}, 32'd0);
        chk("miss_latency", lat, 32'd9);
        chk("miss_walks", n_walk - w0, 32'd1);

        // Hit vectors
        preload(20'h00003, 20'hABCDE);
        preload(20'h12345, 20'h00077);
        for (int i = 0; i < 4; i++) begin
            w0 = n_walk;
            run_txn(vecs[i].port, vecs[i].vaddr, lat, pa, pf, dcyc);
            chk($sformatf("hit%0d_paddr", i), pa, vecs[i].paddr);
            chk($sformatf("hit%0d_pfault", i), {31'b0, pf}, {31'b0, vecs[i].pfault});
            chk($sformatf("hit%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("hit%0d_no_walk", i), n_walk - w0, 32'd0);
        end

        // Page fault: invalid PTE, unfault then flush then done
        mem_lat = 1; mem_data = 32'h0;
        run_txn(1, 32'h00002004, lat, pa, pf, dcyc);
        chk("pf_walk_addr", walk_addr, 32'h00010008);
        chk("pf_pfault", {31'b0, pf}, 32'd1);
        chk("pf_paddr", pa, 32'h0);
        chk("pf_latency", lat, 32'd7);
        chk("pf_flush_after_unfault", f_cyc - u_cyc, 32'd1);
        chk("pf_done_after_flush", dcyc - f_cyc, 32'd1);

        // Arbitration: both ports held valid, all hits
        preload(20'h00005, 20'h00500);
        preload(20'h00006, 20'h00600);
        @(negedge clk);
        req_vaddr[0] = 32'h00005123;
        req_vaddr[1] = 32'h00006456;
        req_valid    = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = |req_done;
            end
            chk($sformatf("arb%0d_done", k), {31'b0, got}, 32'd1);
            aport[k] = req_done[1];
            dc[k]    = cyc;
            apa[k]   = req_paddr;
        end
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("arb%0d_port", k), {31'b0, aport[k]}, k % 2);
            chk($sformatf("arb%0d_paddr", k), apa[k], (k % 2 == 0) ? 32'h00500123 : 32'h00600456);
            if (k > 0) chk($sformatf("arb%0d_gap", k), dc[k] - dc[k-1], 32'd4);
        end

        // Replay still faults: single walk then pfault
        force_fault = 1'b1; mem_lat = 0; mem_data = 32'h00042001; w0 = n_walk;
        run_txn(0, 32'h00007010, lat, pa, pf, dcyc);
        force_fault = 1'b0;
        chk("replay_walk_addr", walk_addr, 32'h0001001C);
        chk("replay_walks", n_walk - w0, 32'd1);
        chk("replay_pfault", {31'b0, pf}, 32'd1);
        chk("replay_paddr", pa, 32'h0);
        chk("replay_latency", lat, 32'd7);

        // Asynchronous reset in the middle of a walk
        mem_lat = 50; mem_data = 32'h0;
        @(negedge clk);
        req_vaddr[0] = 32'h00008000;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        chk("rst_walk_reached", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1 chk("rst_outputs_mid_walk", {31'b0, outs_or}, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        preload(20'h00009, 20'h00900);
        run_txn(0, 32'h00009ABC, lat, pa, pf, dcyc);
        chk("post_rst_paddr", pa, 32'h00900ABC);
        chk("post_rst_latency", lat, 32'd3);

        chk("strobe_overlap", n_overlap, 32'd0);
        chk("strobe_width", n_wide, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
